multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset core (LW, SW, J, BEQ, BNE, R-type ADD/SUB/AND/OR/SLT).
//  Sequences one shared ALU, one unified instruction/data memory and the register file over
//  FETCH/DECODE/EXEC/MEM/WB cycles. Handshakes with variable-latency memory via memReady.
//  Replaces the single-cycle decoder for the multi-cycle datapath.
// PARAMETERS
//  CNT_W         32  width of retired-instruction counter (used only with INSTR_COUNT_EN)
//  MEM_WAIT_MAX  15  max extra cycles to wait for memReady before bus-error abort (1..255)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      reset, asynchronous, active-low
//  opcode        in   6      IR[31:26], valid from the cycle after FETCH completes
//  func          in   6      IR[5:0]
//  zero          in   1      ALU zero flag, same cycle
//  memReady      in   1      memory access completes this cycle
//  pcWriteS      out  1      PC load enable (branch condition already resolved)
//  iOrDS         out  1      mem address: 0=PC, 1=ALUOut
//  memReadS      out  1      memory read request
//  memWriteS     out  1      memory write request
//  irWriteS      out  1      IR load enable
//  regDstS       out  1      write reg: 0=rt, 1=rd
//  memToRegS     out  1      write data: 0=ALUOut, 1=MDR
//  writeRegS     out  1      register-file write enable
//  aluSrcAS      out  1      ALU A: 0=PC, 1=regA
//  aluSrcBS      out  2      ALU B: 00=regB, 01=4, 10=signext(imm), 11=signext(imm)<<2
//  aluS          out  3      0=add, 1=sub, 2=and, 3=or, 4=slt
//  pcSrcS        out  2      PC source: 00=ALU result, 01=ALUOut, 10=jump target
//  illegalS      out  1      1-cycle pulse: unsupported opcode/func, instruction dropped
//  busErrS       out  1      1-cycle pulse: memReady timeout
//  instrCount    out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset: rst_n low -> state=FETCH, opcode/func latches=0, wait counter=0, instrCount=0;
//   all outputs forced to 0 while rst_n low. Outputs are Moore decodes of state, except
//   irWriteS/pcWriteS (gated by memReady in FETCH) and pcWriteS in BRANCH (uses zero).
//  Unlisted outputs are 0 in every state.
//  FETCH:    memReadS=1, iOrDS=0, aluSrcAS=0, aluSrcBS=01, add, pcSrcS=00; irWriteS=pcWriteS=memReady;
//            stay until memReady, then DECODE.
//  DECODE:   aluSrcAS=0, aluSrcBS=11, add (branch target -> ALUOut); latch opcode/func;
//            LW/SW->MEM_ADDR, R(0)->R_EXEC, BEQ/BNE->BRANCH, J->JUMP, else illegalS=1 -> FETCH.
//  MEM_ADDR: aluSrcAS=1, aluSrcBS=10, add; LW->MEM_RD, SW->MEM_WR.
//  MEM_RD:   memReadS=1, iOrDS=1; wait memReady -> MEM_WB.
//  MEM_WB:   writeRegS=1, memToRegS=1, regDstS=0 -> FETCH (retire).
//  MEM_WR:   memWriteS=1, iOrDS=1; wait memReady -> FETCH (retire).
//  R_EXEC:   aluSrcAS=1, aluSrcBS=00, aluS from latched func; unknown func -> illegalS=1, FETCH; else R_WB.
//  R_WB:     writeRegS=1, regDstS=1, memToRegS=0, aluS held -> FETCH (retire).
//  BRANCH:   aluSrcAS=1, aluSrcBS=00, sub, pcSrcS=01; pcWriteS = BEQ ? zero : ~zero -> FETCH (retire).
//  JUMP:     pcSrcS=10, pcWriteS=1 -> FETCH (retire).
//  Latency at memReady=1: BEQ/BNE/J 3 cycles, SW/R-type 4, LW 5.
//  Wait counter: counts cycles with memReady=0 in FETCH/MEM_RD/MEM_WR; clears on state change.
//   At count==MEM_WAIT_MAX with memReady still 0: busErrS=1, next state FETCH, no write issued.
//   memReady=1 in that same cycle wins (normal completion, no busErrS).
//  illegalS and busErrS are never asserted together; neither counts as retire.
//  opcode/func changes after DECODE are ignored (latched copies are used).
// CONFIGURATION
//  INSTR_COUNT_EN defined: instrCount increments by 1 on each retire, wraps at 2^CNT_W-1 -> 0.
//  Not defined: instrCount tied to 0, no counter flops.
// TESTING
//  R-type ADD (op=0, func=32), memReady=1 -> 4 cycles; R_WB has writeRegS=1, regDstS=1, aluS=0.
//  LW (op=35), memReady low 3 cycles in MEM_RD -> MEM_WB 4 cycles after MEM_RD entry, memToRegS=1.
//  BEQ (op=4), zero=1 -> pcWriteS=1 in BRANCH; BNE (op=5), zero=1 -> pcWriteS=0; both pcSrcS=01.
//  op=8 -> illegalS pulse in DECODE, back to FETCH, no writeRegS/memWriteS, count unchanged.
//  memReady held 0 in MEM_WR -> busErrS after MEM_WAIT_MAX+1 cycles, FETCH, memWriteS deasserted.
//  rst_n low mid-MEM_WR -> all outputs 0 immediately; after release FETCH, instrCount=0 (_EN set).

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset core (LW, SW, J, BEQ, BNE, ADD/SUB/AND/OR/SLT).
// Latency: outputs are same-cycle decodes of the current state (FETCH/BRANCH gate on memReady/zero).
// Backpressure: FETCH/MEM_RD/MEM_WR stall on memReady; MEM_WAIT_MAX+1 stalled cycles abort with busErrS.
//
// Ports: clk/rst_n (async active-low); opcode/func from IR; zero from ALU; memReady from memory;
//   datapath controls pcWriteS..pcSrcS; illegalS/busErrS error pulses; instrCount retired count.
// Optional feature: define INSTR_COUNT_EN to build the retired-instruction counter
//   (otherwise instrCount is tied to 0 and no counter flops exist).
module multicycle_controller #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWriteS,
  output logic             iOrDS,
  output logic             memReadS,
  output logic             memWriteS,
  output logic             irWriteS,
  output logic             regDstS,
  output logic             memToRegS,
  output logic             writeRegS,
  output logic             aluSrcAS,
  output logic [1:0]       aluSrcBS,
  output logic [2:0]       aluS,
  output logic [1:0]       pcSrcS,
  output logic             illegalS,
  output logic             busErrS,
  output logic [CNT_W-1:0] instrCount
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state, nxt;
  logic [5:0] op_q, fn_q;
  logic [7:0] wait_cnt;

  // R-type func decode: {supported, alu op}
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'd32:   r_alu = {1'b1, 3'd0};
      6'd34:   r_alu = {1'b1, 3'd1};
      6'd36:   r_alu = {1'b1, 3'd2};
      6'd37:   r_alu = {1'b1, 3'd3};
      6'd42:   r_alu = {1'b1, 3'd4};
      default: r_alu = {1'b0, 3'd0};
    endcase
  endfunction

  logic [3:0] r_dec;
  logic       mem_state, timeout;

  assign r_dec     = r_alu(fn_q);
  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // memReady arriving on the last allowed cycle still completes normally
  assign timeout   = mem_state && !memReady && (wait_cnt == WAIT_MAX);

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    if (memReady) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   nxt = S_MEM_ADDR;
          OP_R:           nxt = S_R_EXEC;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          default:        nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (memReady) nxt = S_MEM_WB; else if (timeout) nxt = S_FETCH;
      S_MEM_WB:   nxt = S_FETCH;
      S_MEM_WR:   if (memReady || timeout) nxt = S_FETCH;
      S_R_EXEC:   nxt = r_dec[3] ? S_R_WB : S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      op_q     <= '0;
      fn_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= opcode;
        fn_q <= func;
      end
      // a FETCH timeout stays in FETCH, so clear explicitly on timeout too
      if (!mem_state || nxt != state || timeout)
        wait_cnt <= '0;
      else if (!memReady)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       write_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  ctl_t ctl, ctl_out;

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = memReady;
        ctl.pc_write  = memReady;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_J: ctl.illegal = 1'b0;
          default:                                  ctl.illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctl.write_reg  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu       = r_dec[2:0];
        ctl.illegal   = !r_dec[3];
      end
      S_R_WB: begin
        ctl.write_reg = 1'b1;
        ctl.reg_dst   = 1'b1;
        ctl.alu       = r_dec[2:0];
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu       = 3'd1;
        ctl.pc_src    = 2'b01;
        ctl.pc_write  = (op_q == OP_BEQ) ? zero : !zero;
      end
      S_JUMP: begin
        ctl.pc_src   = 2'b10;
        ctl.pc_write = 1'b1;
      end
      default: ctl = '0;
    endcase
    ctl.bus_err = timeout;
  end

  // outputs are held low for the whole time reset is asserted
  assign ctl_out   = rst_n ? ctl : '0;
  assign pcWriteS  = ctl_out.pc_write;
  assign iOrDS     = ctl_out.i_or_d;
  assign memReadS  = ctl_out.mem_read;
  assign memWriteS = ctl_out.mem_write;
  assign irWriteS  = ctl_out.ir_write;
  assign regDstS   = ctl_out.reg_dst;
  assign memToRegS = ctl_out.mem_to_reg;
  assign writeRegS = ctl_out.write_reg;
  assign aluSrcAS  = ctl_out.alu_src_a;
  assign aluSrcBS  = ctl_out.alu_src_b;
  assign aluS      = ctl_out.alu;
  assign pcSrcS    = ctl_out.pc_src;
  assign illegalS  = ctl_out.illegal;
  assign busErrS   = ctl_out.bus_err;

`ifdef INSTR_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = (state == S_MEM_WB) || (state == S_R_WB) || (state == S_BRANCH) ||
                  (state == S_JUMP) || ((state == S_MEM_WR) && memReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (retire)
      cnt_q <= cnt_q + 1'b1;
  end

  assign instrCount = cnt_q;
`else
  assign instrCount = '0;
`endif

endmodule
